alu_acc_sequencer: RTL

Sequencing stage directly upstream of the combinational alu. It accepts operation commands over a valid/ready handshake and drives the alu operand A, operand B and select inputs from registers. It captures the alu result back into an accumulator, so one command can apply the same operation 1 to 8 times in a row. It maintains carry, zero and negative flags and pulses done when each command completes.

---
 rtl/alu_acc_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: command sequencer that sits in front of the combinational alu.
// It registers operand B and the select, feeds the accumulator back as operand A,
// and runs one command's operation 1 to 8 times. It keeps carry/zero/neg flags
// and pulses done once per completed command.
module alu_acc_sequencer #(
    parameter int unsigned SIZE = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_load,
    input  logic [3:0]      cmd_sel,
    input  logic [SIZE-1:0] cmd_b,
    input  logic [2:0]      cmd_rep,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [SIZE:0]   alu_out,
    output logic [SIZE-1:0] acc,
    output logic            carry,
    output logic            zero,
    output logic            neg,
    output logic            busy,
    output logic            done
);

    localparam int unsigned REP_W = 3;

    // sel[3:2] value for the adder group; only these selects update carry
    localparam logic [1:0] SEL_ARITH = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [SIZE-1:0]   b_reg;
    logic [3:0]        sel_reg;
    logic [REP_W-1:0]  cnt;
    logic [SIZE-1:0]   alu_res;
    logic              accept;

    // The alu sees only registered values, so its inputs move on clock edges only
    assign alu_a   = acc;
    assign alu_b   = b_reg;
    assign alu_sel = sel_reg;

    // Result part of the alu output, without the adder carry
    assign alu_res = alu_out[SIZE-1:0];

    // Ready only in IDLE, and forced low while reset is held
    assign cmd_ready = (state == IDLE) && !rst;

    // Handshake completes on an edge where both sides agree
    assign accept = cmd_valid && cmd_ready;

    // Sequencer FSM with registered datapath, flags and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            b_reg   <= '0;
            sel_reg <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            zero    <= 1'b1;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        busy <= 1'b1;
                        if (cmd_load) begin
                            // Load writes acc directly and completes next cycle
                            acc   <= cmd_b;
                            carry <= 1'b0;
                            zero  <= (cmd_b == '0);
                            neg   <= cmd_b[SIZE-1];
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            b_reg   <= cmd_b;
                            sel_reg <= cmd_sel;
                            cnt     <= cmd_rep;
                            state   <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    // Each EXEC cycle folds one alu result back into acc
                    acc  <= alu_res;
                    zero <= (alu_res == '0);
                    neg  <= alu_res[SIZE-1];
                    if (sel_reg[3:2] == SEL_ARITH) begin
                        carry <= alu_out[SIZE];
                    end
                    // cnt==0 marks the last pass, so it never wraps below zero
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - REP_W'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
